// File: rtl/mdu_ctrl_if.sv
// mdu_ctrl_if: EX-stage <-> multiply/divide unit handshake bundle.
//   op_valid/op_sel/src_a/src_b/flush : pipeline -> MDU (operation request)
//   stallreq/busy                     : MDU -> pipeline (hold request, status)
//   hi_we/lo_we/hi_o/lo_o             : MDU -> hi/lo write port and ID bypass
// The pipeline side uses the master modport, the MDU uses slave.
interface mdu_ctrl_if;
    logic        op_valid;
    logic [2:0]  op_sel;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        flush;
    logic        stallreq;
    logic        busy;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] hi_o;
    logic [31:0] lo_o;

    modport master (
        output op_valid, op_sel, src_a, src_b, flush,
        input  stallreq, busy, hi_we, lo_we, hi_o, lo_o
    );

    modport slave (
        input  op_valid, op_sel, src_a, src_b, flush,
        output stallreq, busy, hi_we, lo_we, hi_o, lo_o
    );
endinterface

// File: rtl/mdu_ctrl.sv
// mdu_ctrl: iterative multiply/divide unit controller for the hi/lo registers.
//   clk  : sole clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : mdu_ctrl_if.slave
//          op_sel 1=MULT 2=MULTU 3=DIV 4=DIVU 5=MTHI 6=MTLO, others no-op.
// MULT/MULTU/DIV/DIVU take 32 CALC cycles (radix-2 shift-add multiply or
// restoring divide on operand magnitudes, signs fixed in DONE). Divide by zero
// skips CALC and returns hi=src_a, lo=all ones. MTHI/MTLO write in the same
// cycle without stalling. flush annuls the current operation.
module mdu_ctrl (
    input  logic           clk,
    input  logic           rst,
    mdu_ctrl_if.slave      bus
);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [2:0]  op_q, op_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [63:0] acc_q, acc_d;
    logic        dz_q, dz_d;

    function automatic logic [31:0] mag(input logic [31:0] v, input logic sgn);
        return (sgn && v[31]) ? (~v + 32'd1) : v;
    endfunction

    // Request decode (current inputs)
    logic in_signed, in_div, in_calc_op, idle_req, accept, mthi, mtlo;

    always_comb begin
        in_signed  = (bus.op_sel == OP_MULT) || (bus.op_sel == OP_DIV);
        in_div     = (bus.op_sel == OP_DIV)  || (bus.op_sel == OP_DIVU);
        in_calc_op = (bus.op_sel >= OP_MULT) && (bus.op_sel <= OP_DIVU);
        idle_req   = (state_q == IDLE) && bus.op_valid && !bus.flush && !rst;
        accept     = idle_req && in_calc_op;
        mthi       = idle_req && (bus.op_sel == OP_MTHI);
        mtlo       = idle_req && (bus.op_sel == OP_MTLO);
    end

    // Datapath on latched operands
    logic        q_signed, q_div;
    logic [31:0] mag_a_q, mag_b_q;
    logic [32:0] mul_sum, trial;
    logic        ge;
    logic [31:0] diff;
    logic [63:0] mul_next, div_next;

    always_comb begin
        q_signed = (op_q == OP_MULT) || (op_q == OP_DIV);
        q_div    = (op_q == OP_DIV)  || (op_q == OP_DIVU);
        mag_a_q  = mag(a_q, q_signed);
        mag_b_q  = mag(b_q, q_signed);

        // Multiply: acc = {partial product, remaining multiplier bits}
        mul_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, mag_a_q} : 33'd0);
        mul_next = {mul_sum, acc_q[31:1]};

        // Divide: acc = {partial remainder, dividend bits / quotient bits}.
        // trial < 2*divisor, so the difference always fits in 32 bits.
        trial    = acc_q[63:31];
        ge       = trial >= {1'b0, mag_b_q};
        diff     = trial[31:0] - mag_b_q;
        div_next = {(ge ? diff : trial[31:0]), acc_q[30:0], ge};
    end

    // Sign fix-up of the final result, applied while in DONE
    logic [63:0] res;
    logic [31:0] quo, rem;

    always_comb begin
        quo = acc_q[31:0];
        rem = acc_q[63:32];
        if (q_signed && (a_q[31] ^ b_q[31])) quo = ~quo + 32'd1;
        if (q_signed && a_q[31])             rem = ~rem + 32'd1;
        if (dz_q)
            res = acc_q;
        else if (q_div)
            res = {rem, quo};
        else if (q_signed && (a_q[31] ^ b_q[31]))
            res = ~acc_q + 64'd1;
        else
            res = acc_q;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        dz_d    = dz_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    op_d  = bus.op_sel;
                    a_d   = bus.src_a;
                    b_d   = bus.src_b;
                    cnt_d = '0;
                    if (in_div && (bus.src_b == '0)) begin
                        acc_d   = {bus.src_a, 32'hFFFF_FFFF};
                        dz_d    = 1'b1;
                        state_d = DONE;
                    end else begin
                        acc_d   = in_div ? {32'd0, mag(bus.src_a, in_signed)}
                                         : {32'd0, mag(bus.src_b, in_signed)};
                        dz_d    = 1'b0;
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                acc_d = q_div ? div_next : mul_next;
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) state_d = DONE;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (bus.flush) state_d = IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            dz_q    <= dz_d;
        end
    end

    // Outputs: strobes only in DONE or on an MTHI/MTLO in IDLE
    logic done_we;

    always_comb begin
        done_we      = (state_q == DONE) && !bus.flush && !rst;
        bus.stallreq = !rst && !bus.flush && (accept || (state_q == CALC));
        bus.busy     = !rst && (state_q != IDLE);
        bus.hi_we    = done_we || mthi;
        bus.lo_we    = done_we || mtlo;
        bus.hi_o     = done_we ? res[63:32] : (mthi ? bus.src_a : '0);
        bus.lo_o     = done_we ? res[31:0]  : (mtlo ? bus.src_a : '0);
    end

endmodule

// File: tb/tb_mdu_ctrl.sv
module tb_mdu_ctrl;
    logic clk;
    logic rst;
    int   errors;
    int   checks;

    mdu_ctrl_if bus ();

    mdu_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_stall"}, bus.stallreq, 0);
        chk({tag, "_hiwe"}, bus.hi_we, 0);
        chk({tag, "_lowe"}, bus.lo_we, 0);
    endtask

    // Reference: plain 64-bit arithmetic on the architectural definitions
    task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] hi, output logic [31:0] lo, output int lat);
        longint      sa, sb;
        logic [63:0] p, q, r;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        lat = 33;
        p   = '0;
        q   = '0;
        r   = '0;
        case (op)
            3'd1: p = 64'(sa * sb);
            3'd2: p = {32'd0, a} * {32'd0, b};
            3'd3: begin
                if (b != 0) begin
                    q = 64'(sa / sb);
                    r = 64'(sa % sb);
                end
                p = {r[31:0], q[31:0]};
            end
            default: begin
                if (b != 0) begin
                    q = {32'd0, a / b};
                    r = {32'd0, a % b};
                end
                p = {r[31:0], q[31:0]};
            end
        endcase
        if ((op == 3'd3 || op == 3'd4) && b == 0) begin
            p   = {a, 32'hFFFF_FFFF};
            lat = 1;
        end
        hi = p[63:32];
        lo = p[31:0];
    endtask

    // Present an op in IDLE at cycle T and follow it through DONE and back to IDLE
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] ehi, elo;
        int          lat;
        model(op, a, b, ehi, elo, lat);
        bus.op_valid = 1'b1;
        bus.op_sel   = op;
        bus.src_a    = a;
        bus.src_b    = b;
        #1;
        chk("acc_busy", bus.busy, 0);
        chk("acc_stall", bus.stallreq, 1);
        chk("acc_hiwe", bus.hi_we, 0);
        for (int k = 1; k <= lat; k++) begin
            tick();
            #1;
            if (k < lat) begin
                chk("calc_stall", bus.stallreq, 1);
                chk("calc_we", {bus.hi_we, bus.lo_we}, 0);
            end else begin
                chk("done_stall", bus.stallreq, 0);
                chk("done_we", {bus.hi_we, bus.lo_we}, 2'b11);
                chk("done_hi", bus.hi_o, ehi);
                chk("done_lo", bus.lo_o, elo);
            end
        end
        bus.op_valid = 1'b0;
        tick();
        #1;
        chk("post_busy", bus.busy, 0);
        chk("post_we", {bus.hi_we, bus.lo_we}, 0);
    endtask

    initial begin
        logic [2:0]  rop;
        logic [31:0] ra, rb;
        errors = 0;
        checks = 0;
        rst = 1'b1;
        bus.op_valid = 1'b0;
        bus.op_sel   = 3'd0;
        bus.src_a    = '0;
        bus.src_b    = '0;
        bus.flush    = 1'b0;

        // Reset state
        tick();
        tick();
        #1;
        chk("rst_busy", bus.busy, 0);
        chk_quiet("rst");
        chk("rst_hio", bus.hi_o, 0);
        chk("rst_loo", bus.lo_o, 0);
        rst = 1'b0;
        tick();

        // Directed arithmetic cases
        run_op(3'd2, 32'hFFFF_FFFF, 32'd2);
        run_op(3'd1, 32'hFFFF_FFFD, 32'd5);
        run_op(3'd3, 32'hFFFF_FFF9, 32'd2);
        run_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op(3'd4, 32'd7, 32'd0);
        run_op(3'd3, 32'hFFFF_FFF9, 32'd0);
        run_op(3'd1, 32'h8000_0000, 32'h8000_0000);
        run_op(3'd3, 32'd7, 32'hFFFF_FFFE);

        // MTHI / MTLO in IDLE, same-cycle write, no stall
        bus.op_valid = 1'b1;
        bus.op_sel   = 3'd5;
        bus.src_a    = 32'h1234;
        #1;
        chk("mthi_hiwe", bus.hi_we, 1);
        chk("mthi_hio", bus.hi_o, 32'h1234);
        chk("mthi_lowe", bus.lo_we, 0);
        chk("mthi_stall", bus.stallreq, 0);
        tick();
        bus.op_sel = 3'd6;
        bus.src_a  = 32'hCAFE_0001;
        #1;
        chk("mtlo_busy", bus.busy, 0);
        chk("mtlo_lowe", bus.lo_we, 1);
        chk("mtlo_loo", bus.lo_o, 32'hCAFE_0001);
        chk("mtlo_hiwe", bus.hi_we, 0);
        tick();
        bus.op_valid = 1'b0;

        // An op presented with flush is not accepted
        bus.op_valid = 1'b1;
        bus.op_sel   = 3'd2;
        bus.src_a    = 32'd3;
        bus.src_b    = 32'd4;
        bus.flush    = 1'b1;
        #1;
        chk_quiet("flsh_idle");
        tick();
        bus.flush    = 1'b0;
        bus.op_valid = 1'b0;
        #1;
        chk("flsh_idle_busy", bus.busy, 0);

        // Flush at CALC counter=10 (cycle T+11), new MULTU accepted next cycle
        bus.op_valid = 1'b1;
        bus.op_sel   = 3'd2;
        bus.src_a    = 32'h1111_1111;
        bus.src_b    = 32'h2222_2222;
        #1;
        chk("fl_acc_stall", bus.stallreq, 1);
        for (int k = 1; k <= 11; k++) begin
            tick();
            #1;
            chk("fl_calc_stall", bus.stallreq, 1);
        end
        bus.flush = 1'b1;
        #1;
        chk_quiet("fl_cycle");
        chk("fl_busy", bus.busy, 1);
        tick();
        bus.flush = 1'b0;
        run_op(3'd2, 32'h0001_0000, 32'h0001_0001);

        // Reset mid-CALC: outputs zero, no strobe afterwards
        bus.op_valid = 1'b1;
        bus.op_sel   = 3'd1;
        bus.src_a    = 32'd9;
        bus.src_b    = 32'd9;
        for (int k = 0; k < 6; k++) tick();
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            #1;
            chk("rm_busy", bus.busy, 0);
            chk_quiet("rm");
            chk("rm_out", {bus.hi_o, bus.lo_o}, 0);
            tick();
        end
        rst = 1'b0;
        bus.op_valid = 1'b0;
        for (int k = 0; k < 40; k++) begin
            #1;
            chk("rm_after", {bus.busy, bus.hi_we, bus.lo_we}, 0);
            tick();
        end

        // Randomized operations against the reference
        for (int n = 0; n < 14; n++) begin
            rop = 3'($urandom_range(1, 4));
            ra  = $urandom;
            case ($urandom_range(0, 5))
                0:       rb = 32'd0;
                1:       rb = 32'($urandom_range(1, 17));
                2:       rb = -32'($urandom_range(1, 17));
                default: rb = $urandom;
            endcase
            run_op(rop, ra, rb);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
